// File: rtl/ram_latency_model.sv
// ram_latency_model
//   Word-addressed backing RAM with a programmable access latency. It serves
//   one read or write request at a time and reports progress through ramstate,
//   so that cache-miss stalls and coherence wait paths see DRAM-like timing.
//
//   Ports
//     CLK       in   1   system clock, rising edge
//     nRST      in   1   synchronous reset, active HIGH despite the name
//     memaddr   in  32   byte address (word aligned, < DEPTH*4)
//     memstore  in  32   write data
//     memREN    in   1   read request, held until ACCESS
//     memWEN    in   1   write request, held until ACCESS
//     ramload   out 32   read data, non-zero only in a read ACCESS cycle
//     ramstate  out  2   FREE=0, BUSY=1, ACCESS=2, ERROR=3
//
//   Parameters
//     DEPTH     number of 32-bit words
//     LAT       wait cycles between request capture and ACCESS (0..15)
module ram_latency_model #(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned LAT   = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] memaddr,
    input  logic [31:0] memstore,
    input  logic        memREN,
    input  logic        memWEN,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  LAT_C   = 4'(LAT);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    typedef enum logic [1:0] {
        RS_FREE   = 2'd0,
        RS_BUSY   = 2'd1,
        RS_ACCESS = 2'd2,
        RS_ERROR  = 2'd3
    } rs_t;

    logic [31:0]   r_mem [DEPTH];

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_addr;
    logic          r_wr;
    logic [31:0]   r_wdata;
    logic          r_rst_d;     // high for the single cycle following reset

    logic          w_any;
    logic          w_in_range;
    logic          w_valid;
    logic          w_err;
    logic          w_same;
    logic [AW-1:0] w_idx;

    state_t        w_next;
    rs_t           w_rs;
    logic          w_latch;
    logic          w_dec;
    logic          w_write;

    assign w_any      = memREN | memWEN;
    assign w_in_range = ({2'b00, memaddr[31:2]} < DEPTH_W);
    assign w_valid    = (memREN ^ memWEN) && (memaddr[1:0] == 2'b00) && w_in_range;
    assign w_err      = w_any && !w_valid;

    // A held request matches the latch when address and op agree; write data
    // only matters for writes.
    assign w_same = (memaddr == r_addr) && (memWEN == r_wr) &&
                    (!r_wr || (memstore == r_wdata));

    assign w_idx    = r_addr[AW+1:2];
    assign ramstate = w_rs;

    always_comb begin
        w_rs    = RS_FREE;
        ramload = '0;
        w_next  = ST_IDLE;
        w_latch = 1'b0;
        w_dec   = 1'b0;
        w_write = 1'b0;

        // Reset and the cycle after it ignore the bus entirely so that a
        // request still held across reset is not captured until it has been
        // seen with reset released for a full cycle.
        if (nRST || r_rst_d) begin
            w_rs   = RS_FREE;
            w_next = ST_IDLE;
        end else if (w_err) begin
            w_rs   = RS_ERROR;
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        w_rs    = RS_BUSY;
                        w_latch = 1'b1;
                        w_next  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!w_any) begin
                        w_rs   = RS_FREE;
                        w_next = ST_IDLE;
                    end else if (!w_same) begin
                        w_rs    = RS_BUSY;
                        w_latch = 1'b1;
                        w_next  = ST_WAIT;
                    end else if (r_cnt != 4'd0) begin
                        w_rs   = RS_BUSY;
                        w_dec  = 1'b1;
                        w_next = ST_WAIT;
                    end else begin
                        w_rs   = RS_ACCESS;
                        w_next = ST_IDLE;
                        if (r_wr) begin
                            w_write = 1'b1;
                        end else begin
                            ramload = r_mem[w_idx];
                        end
                    end
                end
                default: begin
                    w_rs   = RS_FREE;
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_rst_d <= 1'b1;
        end else begin
            r_rst_d <= 1'b0;
            r_state <= w_next;
            if (w_latch) begin
                r_addr  <= memaddr;
                r_wr    <= memWEN;
                r_wdata <= memstore;
                r_cnt   <= LAT_C;
            end else if (w_dec) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Array contents survive reset; w_write is already suppressed under reset.
    always_ff @(posedge CLK) begin
        if (w_write) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

endmodule

// File: tb/tb_ram_latency_model.sv
// tb_ram_latency_model
//   Directed bench for ram_latency_model. Two instances share the request
//   bus: u_dut0 with LAT=2 carries most of the sequence, u_dut1 with LAT=0
//   is checked only in the final section. Each cycle pushes the expected
//   ramstate/ramload for the selected instance into a scoreboard queue and
//   pops it for comparison at the falling edge.
module tb_ram_latency_model;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK;
    logic        nRST;
    logic [31:0] memaddr;
    logic [31:0] memstore;
    logic        memREN;
    logic        memWEN;
    logic [31:0] ramload0, ramload1;
    logic [1:0]  ramstate0, ramstate1;

    typedef struct {
        bit          sel;
        logic [1:0]  st;
        logic [31:0] ld;
        int          stepno;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          stepno = 0;

    ram_latency_model #(.DEPTH(16384), .LAT(2)) u_dut0 (
        .CLK      (CLK),
        .nRST     (nRST),
        .memaddr  (memaddr),
        .memstore (memstore),
        .memREN   (memREN),
        .memWEN   (memWEN),
        .ramload  (ramload0),
        .ramstate (ramstate0)
    );

    ram_latency_model #(.DEPTH(16384), .LAT(0)) u_dut1 (
        .CLK      (CLK),
        .nRST     (nRST),
        .memaddr  (memaddr),
        .memstore (memstore),
        .memREN   (memREN),
        .memWEN   (memWEN),
        .ramload  (ramload1),
        .ramstate (ramstate1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One bus cycle: drive, record expectation, compare at negedge.
    task automatic step(input logic r, input logic re, input logic we,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] es, input logic [31:0] el,
                        input bit sel);
        exp_t        e;
        exp_t        g;
        logic [1:0]  obs_st;
        logic [31:0] obs_ld;
        nRST     = r;
        memREN   = re;
        memWEN   = we;
        memaddr  = a;
        memstore = d;
        e = '{sel, es, el, stepno};
        sb.push_back(e);
        stepno++;
        @(negedge CLK);
        g      = sb.pop_front();
        obs_st = g.sel ? ramstate1 : ramstate0;
        obs_ld = g.sel ? ramload1  : ramload0;
        checks++;
        assert (obs_st === g.st) else begin
            errors++;
            $error("FAIL step %0d dut%0d ramstate: observed %0d expected %0d",
                   g.stepno, g.sel, obs_st, g.st);
        end
        checks++;
        assert (obs_ld === g.ld) else begin
            errors++;
            $error("FAIL step %0d dut%0d ramload: observed %h expected %h",
                   g.stepno, g.sel, obs_ld, g.ld);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, 1'b0);
    endtask

    // Full LAT=2 write: BUSY for cycles 0..2, ACCESS in cycle 3.
    task automatic wr_req(input logic [31:0] a, input logic [31:0] d);
        for (int unsigned i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, a, d, BUSY, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, a, d, ACCESS, 32'h0, 1'b0);
        model[a] = d;
    endtask

    task automatic rd_req(input logic [31:0] a);
        for (int unsigned i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, a, 32'h0, BUSY, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, a, 32'h0, ACCESS, model[a], 1'b0);
    endtask

    initial begin
        nRST     = 1'b1;
        memREN   = 1'b0;
        memWEN   = 1'b0;
        memaddr  = '0;
        memstore = '0;
        @(posedge CLK);
        #1;

        // Reset cycle and the cycle after it
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, 1'b0);
        idle();

        // Write then read back
        wr_req(32'h40, 32'hDEADBEEF);
        idle();
        rd_req(32'h40);
        idle();

        // Preload words used later
        wr_req(32'h80,  32'hAAAA5555); idle();
        wr_req(32'h00,  32'h01010101); idle();
        wr_req(32'h04,  32'h02020202); idle();
        wr_req(32'h14,  32'h05050505); idle();
        wr_req(32'h10,  32'h04040404); idle();
        wr_req(32'h100, 32'h11111111); idle();

        // Abort mid-wait: old value must survive
        step(1'b0, 1'b0, 1'b1, 32'h80, 32'h1234, BUSY, 32'h0, 1'b0);
        idle();
        rd_req(32'h80);
        idle();

        // Address change in cycle 1 restarts the wait; ACCESS in cycle 4
        step(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, BUSY, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, BUSY, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, BUSY, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, BUSY, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, ACCESS, model[32'h14], 1'b0);
        idle();

        // Error cases, each flagged in the same cycle
        step(1'b0, 1'b1, 1'b1, 32'h0,     32'hBADBAD00, ERROR, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h3,     32'hBADBAD01, ERROR, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h10000, 32'h0,        ERROR, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h10000, 32'hBADBAD02, ERROR, 32'h0, 1'b0);
        idle();
        // Word 0 untouched by the erroneous writes
        rd_req(32'h0);

        // Back-to-back reads: second request in the cycle after ACCESS
        rd_req(32'h4);
        rd_req(32'h0);
        idle();

        // Reset during a write wait, request held across reset
        step(1'b0, 1'b0, 1'b1, 32'h100, 32'h22222222, BUSY, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h100, 32'h22222222, BUSY, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h100, 32'h22222222, FREE, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h100, 32'h22222222, FREE, 32'h0, 1'b0);
        idle();
        rd_req(32'h100);
        idle();

        // LAT=0 instance: ACCESS exactly one cycle after the request
        step(1'b0, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, BUSY,   32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, ACCESS, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        FREE,   32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h200, 32'h0,        BUSY,   32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h200, 32'h0,        ACCESS, 32'hCAFEF00D, 1'b1);
        step(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        FREE,   32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
